// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control definitions: sequencer states and common constants.
package riscv_pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         MC_CNT_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX hazard inputs in, per-stage strobes and perf counter out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs1_i;
    logic             id_use_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_memread_i;
    logic             ex_branch_taken_i;
    logic             ex_mc_req_i;
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             ex_hold_o;
    logic             mc_busy_o;
    logic             mc_done_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side: drives hazard conditions, consumes strobes.
    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        output ex_rd_i, ex_memread_i, ex_branch_taken_i, ex_mc_req_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
        input  ex_hold_o, mc_busy_o, mc_done_o, stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        input  ex_rd_i, ex_memread_i, ex_branch_taken_i, ex_mc_req_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
        output ex_hold_o, mc_busy_o, mc_done_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard compare between the ID operands and a load in EX.
// Purely combinational so a second ID lane can instantiate its own copy.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memread_i,
    output logic       hit_o
);

    logic rs1_match;
    logic rs2_match;

    // A load into x0 never produces a value, so it cannot create a hazard.
    always_comb begin
        rs1_match = id_use_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_match = id_use_rs2_i && (id_rs2_i == ex_rd_i);
        hit_o     = ex_memread_i && (ex_rd_i != REG_ZERO) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush and
// multi-cycle EX hold, plus a saturating stall-cycle counter.
// Build option: PIPE_HAZARD_MULDIV_EN enables the MC_BUSY state and mul/div hold;
// without it ex_mc_req_i is ignored and ex_hold_o/mc_busy_o/mc_done_o are tied 0.
//
// state   | meaning
// RUN     | normal flow; branch flush, load-use stall or start of a multi-cycle op
// MC_BUSY | EX occupied by a multi-cycle op; mc_cnt counts remaining stall cycles
module pipe_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    if ((MC_LATENCY < 2) || (MC_LATENCY > 255)) begin : g_bad_latency
        $error("pipe_hazard_ctrl: MC_LATENCY must be in 2..255");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             lu_hit;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
    logic             mc_busy;
    logic             mc_done;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    load_use_detect u_load_use (
        .id_rs1_i     (bus.id_rs1_i),
        .id_rs2_i     (bus.id_rs2_i),
        .id_use_rs1_i (bus.id_use_rs1_i),
        .id_use_rs2_i (bus.id_use_rs2_i),
        .ex_rd_i      (bus.ex_rd_i),
        .ex_memread_i (bus.ex_memread_i),
        .hit_o        (lu_hit)
    );

`ifdef PIPE_HAZARD_MULDIV_EN
    localparam logic [MC_CNT_W-1:0] MC_ONE   = MC_CNT_W'(1);
    localparam logic [MC_CNT_W-1:0] MC_START = MC_CNT_W'(MC_LATENCY - 2);

    pipe_state_e         state_q;
    pipe_state_e         state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q;
    logic [MC_CNT_W-1:0] mc_cnt_d;

    // State and multi-cycle down-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Next state and Mealy strobes; while MC_BUSY the EX op is fixed, so hazard inputs are ignored.
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mc_busy     = 1'b0;
        mc_done     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.ex_branch_taken_i) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (bus.ex_mc_req_i) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    ex_hold    = 1'b1;
                    state_d    = MC_BUSY;
                    mc_cnt_d   = MC_START;
                end else if (lu_hit) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            MC_BUSY: begin
                mc_busy = 1'b1;
                if (mc_cnt_q != '0) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    ex_hold    = 1'b1;
                    mc_cnt_d   = mc_cnt_q - MC_ONE;
                end else begin
                    mc_done = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end
`else
    // Single-state flow: branch flush has priority over load-use stall.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (bus.ex_branch_taken_i) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu_hit) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign ex_hold = 1'b0;
    assign mc_busy = 1'b0;
    assign mc_done = 1'b0;
`endif

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Strobes are forced low asynchronously while reset is asserted.
    assign bus.pc_stall_o    = pc_stall    & ~rst;
    assign bus.ifid_stall_o  = ifid_stall  & ~rst;
    assign bus.ifid_flush_o  = ifid_flush  & ~rst;
    assign bus.idex_bubble_o = idex_bubble & ~rst;
    assign bus.ex_hold_o     = ex_hold     & ~rst;
    assign bus.mc_busy_o     = mc_busy     & ~rst;
    assign bus.mc_done_o     = mc_done     & ~rst;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule
